// File: rtl/muldiv_ctrl_if.sv
// Bundle of EX-stage request signals and HI/LO results exchanged with the
// iterative multiply/divide sequencer.
interface muldiv_ctrl_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            mthi;
  logic            mtlo;
  logic            rd_req;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic            div_zero;
  logic [XLEN-1:0] hi_num;
  logic [XLEN-1:0] lo_num;

  modport master (
    output start, op, src_a, src_b, mthi, mtlo, rd_req, flush,
    input  busy, stall, done, div_zero, hi_num, lo_num
  );

  modport slave (
    input  start, op, src_a, src_b, mthi, mtlo, rd_req, flush,
    output busy, stall, done, div_zero, hi_num, lo_num
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: one operand bit per cycle,
// sign fix-up in a final cycle, and EX-stage stall generation while in flight.
module muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
    if (en) begin
      neg_if = ~v + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      neg_if = v;
    end
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic              is_div_q, is_div_d, done_q, done_d, dz_q, dz_d;

  logic              is_signed_s, busy_s, div_ge_s;
  logic [XLEN:0]     mul_sum_s, div_shift_s;
  logic [XLEN-1:0]   rem_sub_s;
  logic [2*XLEN-1:0] prod_s;

  assign is_signed_s = ~bus.op[0];
  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  assign mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                       (acc_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});
  assign div_shift_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, opb_q});
  assign rem_sub_s   = div_shift_s[XLEN-1:0] - opb_q;
  assign prod_s      = neg_quo_q ? (~acc_q + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_q;

  assign busy_s       = (state_q != S_IDLE);
  assign bus.busy     = busy_s;
  assign bus.stall    = busy_s & (bus.start | bus.mthi | bus.mtlo | bus.rd_req);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi_num   = hi_q;
  assign bus.lo_num   = lo_q;

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.mthi) begin
            hi_d = bus.src_a;
          end else begin
            hi_d = hi_q;
          end
          if (bus.mtlo) begin
            lo_d = bus.src_a;
          end else begin
            lo_d = lo_q;
          end
          if (bus.start) begin
            opa_d     = (is_signed_s & bus.src_a[XLEN-1]) ? neg_if(bus.src_a, 1'b1) : bus.src_a;
            opb_d     = (is_signed_s & bus.src_b[XLEN-1]) ? neg_if(bus.src_b, 1'b1) : bus.src_b;
            neg_quo_d = is_signed_s & (bus.src_a[XLEN-1] ^ bus.src_b[XLEN-1]);
            neg_rem_d = is_signed_s & bus.src_a[XLEN-1];
            is_div_d  = bus.op[1];
            acc_d     = {ZERO_X, bus.op[1] ? opa_d : opb_d};
            cnt_d     = {CNT_W{1'b0}};
            state_d   = bus.op[1] ? S_DIV : S_MUL;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          if (state_q == S_MUL) begin
            acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
          end else if (div_ge_s) begin
            acc_d = {rem_sub_s, acc_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = {div_shift_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_FIX: begin
          if (!is_div_q) begin
            hi_d = prod_s[2*XLEN-1:XLEN];
            lo_d = prod_s[XLEN-1:0];
          end else if (opb_q == ZERO_X) begin
            // Divide by zero returns the original dividend in HI.
            hi_d = neg_if(opa_q, neg_rem_q);
            lo_d = {XLEN{1'b1}};
            dz_d = 1'b1;
          end else begin
            hi_d = neg_if(acc_q[2*XLEN-1:XLEN], neg_rem_q);
            lo_d = neg_if(acc_q[XLEN-1:0], neg_quo_q);
            dz_d = 1'b0;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      acc_q     <= {(2*XLEN){1'b0}};
      opa_q     <= ZERO_X;
      opb_q     <= ZERO_X;
      hi_q      <= ZERO_X;
      lo_q      <= ZERO_X;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl against a plain-arithmetic HI/LO reference.
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] exp_hi, exp_lo;
  logic        exp_dz;

  muldiv_ctrl_if #(.XLEN(32)) bus ();
  muldiv_ctrl #(.XLEN(32), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic definition of each op.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          exp_hi = a; exp_lo = 32'hFFFFFFFF; exp_dz = 1'b1;
        end else begin
          if (op == 2'd2) begin
            q = sa / sb; r = sa % sb;
          end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
          end
          exp_hi = r[31:0]; exp_lo = q[31:0]; exp_dz = 1'b0;
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rd, input logic wr_hi);
    int cycles, busy_cnt, stall_bad;
    model(op, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.mthi = wr_hi;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.mthi = 1'b0; bus.rd_req = rd;
    if (wr_hi) chk("mthi_with_start", bus.hi_num, a);
    cycles = 0; busy_cnt = 0; stall_bad = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (bus.busy) busy_cnt++;
      if (bus.stall !== (bus.busy & rd)) stall_bad++;
    end while (!bus.done && cycles < 100);
    chk("latency", cycles, 32'd34);
    chk("busy_cycles", busy_cnt, 32'd33);
    chk("stall_cycles_wrong", stall_bad, 32'd0);
    chk("hi", bus.hi_num, exp_hi);
    chk("lo", bus.lo_num, exp_lo);
    chk("div_zero", {31'd0, bus.div_zero}, {31'd0, exp_dz});
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("done_single_pulse", {31'd0, bus.done}, 32'd0);
  endtask

  task automatic watch_no_done(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk(tag, seen, 32'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    logic        r_rd;
    bus.start = 1'b0; bus.op = 2'd0; bus.src_a = 32'd0; bus.src_b = 32'd0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.rd_req = 1'b0; bus.flush = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0; exp_dz = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
    chk("rst_hi", bus.hi_num, 32'd0);
    chk("rst_lo", bus.lo_num, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'd0, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    run_op(2'd1, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    run_op(2'd3, 32'd7, 32'd0, 1'b0, 1'b0);
    run_op(2'd0, 32'd9, 32'd9, 1'b0, 1'b0);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op(2'd2, 32'hFFFFFF9C, 32'd0, 1'b1, 1'b0);
    run_op(2'd2, 32'd100, 32'hFFFFFFF9, 1'b0, 1'b1);

    @(negedge clk);
    bus.mtlo = 1'b1; bus.src_a = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus.mtlo = 1'b0;
    exp_lo = 32'hCAFEF00D;
    chk("mtlo_idle", bus.lo_num, exp_lo);
    chk("mtlo_keeps_hi", bus.hi_num, exp_hi);

    for (int i = 0; i < 30; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      if ($urandom_range(0, 7) == 0) r_a = 32'h80000000;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: r_b = 32'hFFFFFFFF;
        2: r_b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      r_rd = 1'($urandom_range(0, 1));
      run_op(r_op, r_a, r_b, r_rd, 1'b0);
    end

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd2; bus.src_a = 32'd12345; bus.src_b = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_hi = 32'd0; exp_lo = 32'd0; exp_dz = 1'b0;
    chk("midop_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midop_rst_hi", bus.hi_num, exp_hi);
    chk("midop_rst_lo", bus.lo_num, exp_lo);
    chk("midop_rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("done_after_reset");

    // Flush of an in-flight MULT leaves HI/LO alone.
    @(negedge clk);
    bus.mthi = 1'b1; bus.src_a = 32'h00001234;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    exp_hi = 32'h00001234;
    chk("mthi_idle", bus.hi_num, exp_hi);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.src_a = 32'd3; bus.src_b = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    watch_no_done("done_after_flush");
    chk("flush_hi", bus.hi_num, exp_hi);
    chk("flush_lo", bus.lo_num, exp_lo);

    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'd1; bus.src_a = 32'd5; bus.src_b = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("start_in_flush_rejected", {31'd0, bus.busy}, 32'd0);

    run_op(2'd0, 32'd6, 32'hFFFFFFFD, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
